// File: rtl/butterfly_addsub.sv
// NTT butterfly add/sub stage: CT mode pairs a with a multiplier product MUL_LAT cycles later,
// GS mode combines a and b directly. Optional macro BF_DIV2_EN halves the GS sum modulo q.
module butterfly_addsub #(
  parameter int                    data_width = 12,
  parameter int                    MUL_LAT    = 4,
  parameter logic [data_width-1:0] q          = 12'd3329
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic [data_width-1:0] prod,
  output logic                  out_valid,
  output logic [data_width-1:0] x,
  output logic [data_width-1:0] y
);

  function automatic logic [data_width-1:0] mod_add(input logic [data_width-1:0] u,
                                                    input logic [data_width-1:0] v);
    logic [data_width:0] s;
    s = {1'b0, u} + {1'b0, v};
    if (s >= {1'b0, q}) begin
      s = s - {1'b0, q};
    end else begin
      s = s;
    end
    return s[data_width-1:0];
  endfunction

  function automatic logic [data_width-1:0] mod_sub(input logic [data_width-1:0] u,
                                                    input logic [data_width-1:0] v);
    logic [data_width:0] d;
    d = {1'b0, u} - {1'b0, v};
    if (d[data_width]) begin
      d = d + {1'b0, q};
    end else begin
      d = d;
    end
    return d[data_width-1:0];
  endfunction

`ifdef BF_DIV2_EN
  // Division by 2 in Z_q: an odd residue becomes even once q (odd) is added.
  function automatic logic [data_width-1:0] mod_half(input logic [data_width-1:0] s);
    logic [data_width:0] t;
    if (s[0]) begin
      t = {1'b0, s} + {1'b0, q};
    end else begin
      t = {1'b0, s};
    end
    return t[data_width:1];
  endfunction
`endif

  logic                  ct_acc_s;
  logic                  gs_acc_s;
  logic                  emerge_s;
  logic                  ct_done_s;
  logic [data_width-1:0] ct_x_s;
  logic [data_width-1:0] ct_y_s;
  logic [data_width-1:0] gs_x_s;
  logic [data_width-1:0] gs_y_s;

  logic [data_width-1:0] dl_a_r [MUL_LAT];
  logic [MUL_LAT-1:0]    dl_v_r;
  logic [2:0]            cnt_r;
  logic                  out_valid_r;
  logic                  out_ct_r;
  logic [data_width-1:0] x_r;
  logic [data_width-1:0] y_r;

  // GS ops wait until every CT op has left the output register, so results never collide.
  assign in_ready  = !(mode && (cnt_r != 3'd0));
  assign ct_acc_s  = in_valid && in_ready && !mode;
  assign gs_acc_s  = in_valid && in_ready && mode;
  assign emerge_s  = dl_v_r[MUL_LAT-1];
  assign ct_done_s = out_valid_r && out_ct_r;

  // Result datapath for both butterfly flavours.
  always_comb begin
    ct_x_s = mod_add(dl_a_r[MUL_LAT-1], prod);
    ct_y_s = mod_sub(dl_a_r[MUL_LAT-1], prod);
    gs_y_s = mod_sub(a, b);
`ifdef BF_DIV2_EN
    gs_x_s = mod_half(mod_add(a, b));
`else
    gs_x_s = mod_add(a, b);
`endif
  end

  // Delay line carrying a alongside the multiplier pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_v_r <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        dl_a_r[i] <= '0;
      end
    end else begin
      dl_v_r[0] <= ct_acc_s;
      dl_a_r[0] <= a;
      for (int i = 1; i < MUL_LAT; i++) begin
        dl_v_r[i] <= dl_v_r[i-1];
        dl_a_r[i] <= dl_a_r[i-1];
      end
    end
  end

  // In-flight CT counter: released only once the CT result has been presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 3'd0;
    end else begin
      case ({ct_acc_s, ct_done_s})
        2'b10:   cnt_r <= cnt_r + 3'd1;
        2'b01:   cnt_r <= cnt_r - 3'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Output register: x/y hold their value between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_ct_r    <= 1'b0;
      x_r         <= '0;
      y_r         <= '0;
    end else begin
      out_valid_r <= emerge_s || gs_acc_s;
      out_ct_r    <= emerge_s;
      if (emerge_s) begin
        x_r <= ct_x_s;
        y_r <= ct_y_s;
      end else if (gs_acc_s) begin
        x_r <= gs_x_s;
        y_r <= gs_y_s;
      end else begin
        x_r <= x_r;
        y_r <= y_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign x         = x_r;
  assign y         = y_r;

endmodule

// File: tb/tb_butterfly_addsub.sv
// Scoreboard bench for butterfly_addsub: directed cases, reset abort and a 10k-op random stream.
// Honours BF_DIV2_EN in its reference model.
module tb_butterfly_addsub;
  localparam int DW  = 12;
  localparam int LAT = 4;
  localparam int Q   = 3329;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] prod;
  logic          out_valid;
  logic [DW-1:0] x;
  logic [DW-1:0] y;

  butterfly_addsub #(.data_width(DW), .MUL_LAT(LAT), .q(12'd3329)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .prod(prod), .out_valid(out_valid), .x(x), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ex;
    int ey;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   prod_sched[int];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_out = 0;
  int   last_x = 0;
  int   last_y = 0;
  int   last_ct_out = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain modular arithmetic on integers.
  function automatic void model(input bit m, input int aa, input int bb, output int ex, output int ey);
    int s;
    s  = (aa + bb) % Q;
    ey = (aa - bb + Q) % Q;
    ex = s;
`ifdef BF_DIV2_EN
    if (m) ex = (s % 2 == 0) ? s / 2 : (s + Q) / 2;
`endif
  endfunction

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && out_valid === 1'b1) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected out_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("x", 32'(x), 32'(e.ex));
        check("y", 32'(y), 32'(e.ey));
        check("out cycle", 32'(cyc), 32'(e.cyc));
      end
      last_x = int'(x);
      last_y = int'(y);
    end
  end

  // One clock of stimulus; pp < 0 picks a random product for a CT op.
  task automatic step(input bit v, input bit m, input int aa, input int bb, input int pp,
                      output bit acc);
    int p, ex, ey;
    @(posedge clk);
    #1;
    in_valid = v;
    mode     = m;
    a        = DW'(aa);
    b        = DW'(bb);
    if (prod_sched.exists(cyc)) begin
      prod = DW'(prod_sched[cyc]);
      prod_sched.delete(cyc);
    end else begin
      prod = DW'($urandom_range(Q - 1, 0));
    end
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(!(m && cyc <= last_ct_out)));
    acc = v && (in_ready === 1'b1);
    if (acc) begin
      n_acc++;
      if (!m) begin
        p = (pp < 0) ? int'($urandom_range(Q - 1, 0)) : pp;
        prod_sched[cyc + LAT] = p;
        model(1'b0, aa, p, ex, ey);
        sb.push_back('{ex, ey, cyc + LAT + 1});
        last_ct_out = cyc + LAT + 1;
      end else begin
        model(1'b1, aa, bb, ex, ey);
        sb.push_back('{ex, ey, cyc + 1});
      end
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && (sb.size() != 0 || prod_sched.size() != 0); i++) begin
      step(1'b0, 1'b0, 0, 0, -1, acc);
    end
    check("drain pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b1;
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset x", 32'(x), 32'd0);
    check("reset y", 32'(y), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    prod_sched.delete();
    last_ct_out = -1;
    n_acc = 0;
    n_out = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bit acc;
    int stalls, tries, m, aa, bb;
    rst = 1'b0; in_valid = 1'b0; mode = 1'b0; a = '0; b = '0; prod = '0;
    do_reset();

    // CT example: a=100, prod=3300 -> x=71, y=129 after MUL_LAT+1 cycles.
    step(1'b1, 1'b0, 100, 0, 3300, acc);
    check("ct accept", 32'(acc), 32'd1);
    drain();
    check("ct x 71", 32'(last_x), 32'd71);
    check("ct y 129", 32'(last_y), 32'd129);

    step(1'b1, 1'b1, 3000, 1000, -1, acc);
    drain();
`ifdef BF_DIV2_EN
    check("gs x 2000", 32'(last_x), 32'd2000);
`else
    check("gs x 671", 32'(last_x), 32'd671);
`endif
    check("gs y 2000", 32'(last_y), 32'd2000);

    step(1'b1, 1'b1, 3328, 3328, -1, acc);
    drain();
`ifndef BF_DIV2_EN
    check("gs max x", 32'(last_x), 32'd3327);
`endif
    check("gs max y", 32'(last_y), 32'd0);
    step(1'b1, 1'b1, 0, 3328, -1, acc);
    drain();
`ifndef BF_DIV2_EN
    check("gs zero x", 32'(last_x), 32'd3328);
`endif
    check("gs zero y", 32'(last_y), 32'd1);

    // Idle cycles with junk operands must leave x/y alone.
    step(1'b0, 1'b1, 5, 7, -1, acc);
    step(1'b0, 1'b0, 9, 1, -1, acc);
    step(1'b0, 1'b0, 0, 0, -1, acc);
    check("hold x", 32'(x), 32'(last_x));
    check("hold out_valid", 32'(out_valid), 32'd0);

    // Four back-to-back CT ops, then a GS op that must stall 5 cycles.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, int'($urandom_range(Q - 1, 0)), 0, -1, acc);
      check("ct burst accept", 32'(acc), 32'd1);
    end
    stalls = 0;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      step(1'b1, 1'b1, 1234, 2345, -1, acc);
      if (!acc) stalls++;
    end
    check("ct->gs stall cycles", 32'(stalls), 32'd5);
    drain();

    // Reset with three CT ops in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 77, 0, 11, acc);
    do_reset();
    step(1'b1, 1'b1, 1, 2, -1, acc);
    check("post-reset gs ready", 32'(acc), 32'd1);
    drain();
    check("post-reset count", 32'(n_out), 32'(n_acc));

    // Random mixed stream.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(3, 0) == 0) step(1'b0, 1'($urandom_range(1, 0)), 0, 0, -1, acc);
      m  = int'($urandom_range(2, 0) == 0);
      aa = int'($urandom_range(Q - 1, 0));
      bb = int'($urandom_range(Q - 1, 0));
      if ($urandom_range(15, 0) == 0) aa = Q - 1;
      if ($urandom_range(15, 0) == 0) bb = Q - 1;
      acc = 1'b0;
      for (tries = 0; tries < 20 && !acc; tries++) begin
        step(1'b1, 1'(m), aa, bb, -1, acc);
      end
      if (!acc) check("random accept timeout", 32'd0, 32'd1);
    end
    step(1'b0, 1'b0, 0, 0, -1, acc);
    drain();
    check("out count == accept count", 32'(n_out), 32'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
